// File: rtl/pq_barrett_reduce_pkg.sv
// Shared modular-arithmetic constants for the PQ datapath: Barrett parameters
// for the default modulus and the Kyber alternate, plus a consistency helper.
package pq_defines;

  localparam int unsigned PQ_Q         = 12289;
  localparam int unsigned PQ_BARRETT_K = 28;
  localparam int unsigned PQ_BARRETT_M = 21843;

  localparam int unsigned KYBER_Q         = 3329;
  localparam int unsigned KYBER_BARRETT_K = 24;
  localparam int unsigned KYBER_BARRETT_M = 5039;

  localparam int unsigned X_IN_W = 32;
  localparam int unsigned X_W    = 28;
  localparam int unsigned P_W    = 43;
  localparam int unsigned T_W    = 15;
  localparam int unsigned R2_W   = 17;
  localparam int unsigned R_W    = 16;
  localparam int unsigned CNT_W  = 16;

  // M must equal floor(2^K / Q) and Q^2 must fit under 2^K for the
  // single-estimate quotient to leave a residue below 3Q.
  function automatic bit barrett_params_ok(int unsigned q, int unsigned k, int unsigned m);
    longint unsigned two_k;
    longint unsigned qq;
    two_k = 64'd1 << k;
    qq    = 64'(q);
    return (q > 32'd2) && (q < 32'd16384) && (k <= 32'd28) &&
           (qq * qq <= two_k) && (64'(m) == two_k / qq);
  endfunction

  localparam bit PQ_PARAMS_OK    = barrett_params_ok(PQ_Q, PQ_BARRETT_K, PQ_BARRETT_M);
  localparam bit KYBER_PARAMS_OK = barrett_params_ok(KYBER_Q, KYBER_BARRETT_K, KYBER_BARRETT_M);

endpackage

// File: rtl/pq_barrett_reduce_if.sv
// Stream interface into and out of the Barrett reduction stage.
// A beat moves on a side exactly when its valid and ready are both high at a
// rising clock edge; the producer holds valid and data stable until that edge.
interface pq_barrett_reduce_if;
  import pq_defines::*;

  logic              in_valid_i;
  logic              in_ready_o;
  logic [X_IN_W-1:0] x_i;
  logic              out_valid_o;
  logic              out_ready_i;
  logic [R_W-1:0]    r_o;

  modport master (
    output in_valid_i, x_i, out_ready_i,
    input  in_ready_o, out_valid_o, r_o
  );

  modport slave (
    input  in_valid_i, x_i, out_ready_i,
    output in_ready_o, out_valid_o, r_o
  );

endinterface

// File: rtl/pq_barrett_reduce_corr.sv
// Two-step conditional subtractor: folds a residue in [0, 3Q) into [0, Q).
module pq_barrett_corr
  import pq_defines::*;
#(
  parameter int unsigned Q = PQ_Q
) (
  input  logic [R2_W-1:0] r_i,
  output logic [R_W-1:0]  r_o
);

  localparam logic [R2_W-1:0] Q1 = R2_W'(Q);
  localparam logic [R2_W-1:0] Q2 = R2_W'(2 * Q);

  always_comb begin
    r_o = R_W'(r_i);
    if (r_i >= Q2) begin
      r_o = R_W'(r_i - Q2);
    end else if (r_i >= Q1) begin
      r_o = R_W'(r_i - Q1);
    end
  end

endmodule

// File: rtl/pq_barrett_reduce.sv
// Three-stage stallable Barrett reduction x mod Q for products x < Q^2,
// with a sticky out-of-range flag and a wrapping output handshake counter.
module pq_barrett_reduce
  import pq_defines::*;
#(
  parameter int unsigned Q = PQ_Q,
  parameter int unsigned K = PQ_BARRETT_K,
  parameter int unsigned M = PQ_BARRETT_M
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              clr_i,
  pq_barrett_reduce_if.slave bus,
  output logic              err_o,
  output logic [CNT_W-1:0]  cnt_o,
  output logic              busy_o
);

  localparam logic [X_IN_W-1:0] Q_SQ = X_IN_W'(Q * Q);

  logic             adv, acc, oor_in, out_hs;
  logic [P_W-1:0]   p1_d;
  logic [T_W-1:0]   t2;
  logic [X_W-1:0]   tq2;
  logic [R2_W-1:0]  r2_d;
  logic [R_W-1:0]   corr_r;
  logic [R_W-1:0]   r3_d;

  logic [X_W-1:0]   x1_q;
  logic [P_W-1:0]   p1_q;
  logic             v1_q, oor1_q;
  logic [R2_W-1:0]  r2_q;
  logic             v2_q, oor2_q;
  logic [R_W-1:0]   r3_q;
  logic             v3_q;
  logic             err_q, err_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;

  // The whole pipe moves as one; a stalled output freezes every stage.
  assign adv    = ~v3_q | bus.out_ready_i;
  assign acc    = bus.in_valid_i & adv;
  assign oor_in = bus.x_i >= Q_SQ;
  assign out_hs = v3_q & bus.out_ready_i;

  assign p1_d = P_W'(bus.x_i[X_W-1:0]) * P_W'(M);
  assign t2   = T_W'(p1_q >> K);
  assign tq2  = X_W'(t2) * X_W'(Q);
  // Only the low bits survive: the true residue is known to be below 3Q.
  assign r2_d = R2_W'(x1_q - tq2);

  pq_barrett_corr #(.Q(Q)) u_corr (
    .r_i (r2_q),
    .r_o (corr_r)
  );

  assign r3_d = oor2_q ? '0 : corr_r;

  assign err_d = (err_q & ~clr_i) | (acc & oor_in);

  always_comb begin
    cnt_d = cnt_q;
    if (clr_i) begin
      cnt_d = '0;
    end else if (out_hs) begin
      cnt_d = cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      x1_q   <= '0;
      p1_q   <= '0;
      v1_q   <= 1'b0;
      oor1_q <= 1'b0;
      r2_q   <= '0;
      v2_q   <= 1'b0;
      oor2_q <= 1'b0;
      r3_q   <= '0;
      v3_q   <= 1'b0;
      err_q  <= 1'b0;
      cnt_q  <= '0;
    end else begin
      if (adv) begin
        x1_q   <= bus.x_i[X_W-1:0];
        p1_q   <= p1_d;
        v1_q   <= acc;
        oor1_q <= acc & oor_in;
        r2_q   <= r2_d;
        v2_q   <= v1_q;
        oor2_q <= oor1_q;
        r3_q   <= r3_d;
        v3_q   <= v2_q;
      end
      err_q <= err_d;
      cnt_q <= cnt_d;
    end
  end

  assign bus.in_ready_o  = adv;
  assign bus.out_valid_o = v3_q;
  assign bus.r_o         = r3_q;
  assign err_o           = err_q;
  assign cnt_o           = cnt_q;
  assign busy_o          = v1_q | v2_q | v3_q;

endmodule

// File: doc/pq_barrett_reduce.md
# pq_barrett_reduce

Pipelined Barrett modular reduction stage for the post-quantum datapath. It sits directly downstream of the multiplier's MUL_PQ/MUL_DOT16 product path. It accepts one unreduced product x < Q² per cycle and returns x mod Q in [0, Q). The result goes to the EX writeback mux or the NTT butterfly buffer. The block is a three-stage, fully stallable valid/ready pipeline with an output element counter and a sticky range-error flag.

## Interface
- Q, default 12289: modulus; 2 < Q < 2^14.
- K, default 28: Barrett shift; requires Q² ≤ 2^K ≤ 2^28.
- M, default 21843: Barrett constant, floor(2^K / Q); must agree with Q and K.
- clk  in  1: clock, rising edge.
- rst  in  1: reset, asynchronous, active-high.
- clr_i  in  1: synchronous clear of err_o and cnt_o.
- in_valid_i  in  1: x_i is valid.
- in_ready_o  out  1: stage accepts x_i this cycle.
- x_i  in  32: unreduced product, unsigned.
- out_valid_o  out  1: r_o is valid.
- out_ready_i  in  1: consumer accepts r_o.
- r_o  out  16: reduced value, zero-extended.
- err_o  out  1: sticky flag, set when an input with x_i ≥ Q² was accepted.
- cnt_o  out  16: count of output handshakes, wraps.
- busy_o  out  1: any stage holds valid data.

## Operation
- Accept: the input handshake occurs when in_valid_i & in_ready_o.
- Advance condition: adv = ~out_valid_o | out_ready_i.
  - in_ready_o = adv.
  - All three stages shift together when adv=1 and hold when adv=0.
  - No bubbles are collapsed.
- S1: register x (28 bits), p = x·M (43 bits), v1 = handshake, oor = (x_i ≥ Q²).
- S2:
  - t = p >> K (15 bits).
  - r2 = x − t·Q, computed in 17 bits. The result is guaranteed to be in [0, 3Q).
  - Carry v2 and oor.
- S3:
  - If r2 ≥ 2Q, output r2 − 2Q.
  - Else if r2 ≥ Q, output r2 − Q.
  - Else output r2.
  - If oor is set, r_o = 0.
  - out_valid_o = v3.
- err_o:
  - Set on any accepted input with oor, at the cycle of acceptance.
  - Cleared only by rst or clr_i.
  - If clr_i and a new oor acceptance occur in the same cycle, set wins.
- cnt_o:
  - Increments on each out_valid_o & out_ready_i.
  - Wraps 0xFFFF → 0.
  - If clr_i and a handshake occur in the same cycle, cnt_o becomes 0.
- busy_o = v1 | v2 | v3.

## Timing
- Reset values:
  - in_ready_o = 1.
  - out_valid_o = 0, r_o = 0, err_o = 0, cnt_o = 0, busy_o = 0.
  - All valid bits are cleared; data registers are don't-care except r_o.
- Latency and throughput:
  - An input accepted at edge n appears at r_o after edge n+3, provided adv held.
  - Throughput is 1 per cycle while out_ready_i = 1.
- Back-pressure:
  - With out_valid_o=1 and out_ready_i=0, r_o and out_valid_o are stable.
  - in_ready_o=0 in that case.
  - Upstream must hold x_i and in_valid_i; the block does not sample x_i.
- Pipeline states: there is no FSM, only the valid vector {v1,v2,v3}.
  - Empty: 000, busy_o=0.
  - Fill: bits shift toward v3.
  - Drain: in_valid_i=0 shifts zeros in.
  - Full with stall: 111 held.
- Reset mid-operation: asserting rst at any time discards all in-flight data immediately, with no output handshake.
- clr_i does not affect in-flight data.

## Structure
- Shared package pq_defines holds:
  - PQ_Q, PQ_BARRETT_K, PQ_BARRETT_M, with localparam-checked consistency.
  - The Kyber set (3329, 24, 5039) as an alternate.
- One natural sub-module, pq_barrett_corr: the S3 combinational two-step conditional subtractor, reusable by the butterfly unit.
- Multiplication by constants M and Q is left to synthesis. Width rules are as listed above; truncation is explicit.

## Test plan
- Corner values, streamed back-to-back with out_ready_i=1:
  - x=0 → 0; x=12289 → 0 (exercises correction); x=12290 → 1; x=151019520 (Q²−1) → 12288.
  - Outputs arrive on 4 consecutive cycles starting 3 cycles after the first accept; cnt_o=4 afterwards.
- Back-pressure: fill the pipe with x=1,2,3, then hold out_ready_i=0 for 5 cycles.
  - in_ready_o=0 and r_o=1 stable throughout.
  - On release, 1, 2, 3 emerge on consecutive cycles.
- Out of range: x=151019521 → r_o=0, err_o=1 from the accept cycle onward.
  - clr_i pulse → err_o=0 and cnt_o=0.
  - clr_i simultaneous with a new out-of-range accept → err_o=1.
- Reset mid-flight: accept 2 values, assert rst one cycle later.
  - out_valid_o=0 and busy_o=0 immediately.
  - No output ever appears for those values.
- Random: 10^5 random x < Q² with random out_ready_i toggling.
  - Scoreboard checks r_o == x mod Q in order.
  - cnt_o equals the handshake count modulo 2^16.
